// File: rtl/hzu_sb_if.sv
// hzu_sb_if: pipeline <-> hazard unit signal bundle.
// The master side (pipeline) drives register addresses and stage control;
// the slave side (hazard unit) returns stall/flush/freeze/forward controls.
// Performance counter outputs exist only when HZU_PERF_CNT_EN is defined.
interface hzu_sb_if #(
  parameter int NREG  = 32,
  parameter int AW    = $clog2(NREG),
  parameter int CNT_W = 32
);
  // ID stage
  logic [AW-1:0]   rs1_addr_id, rs2_addr_id, rd_addr_id;
  logic            rd_we_id, is_store_id, is_long_id;
  // EX stage
  logic [AW-1:0]   rd_addr_ex, rs1_addr_ex, rs2_addr_ex;
  logic            rd_we_ex, is_load_ex, tk_brnch_ex, long_issue_ex;
  // MDU completion
  logic            long_done;
  logic [AW-1:0]   long_done_rd;
  // MEM stage
  logic [AW-1:0]   rd_addr_mem, rs2_addr_mem;
  logic            rd_we_mem, is_load_mem, is_store_mem, dmem_busy;
  // WB stage
  logic [AW-1:0]   rd_addr_wb;
  logic            rd_we_wb;
  // Controls back to the pipeline
  logic [1:0]      forward_a_sel, forward_b_sel, forward_store_sel;
  logic            stall, flush_if_id, flush_id_ex, freeze;
  logic [NREG-1:0] sb_pending;
  logic            sb_full;
`ifdef HZU_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_cyc, perf_sb_stall_cyc, perf_flush_cnt;
`endif

  modport master (
    output rs1_addr_id, rs2_addr_id, rd_addr_id, rd_we_id, is_store_id, is_long_id,
    output rd_addr_ex, rs1_addr_ex, rs2_addr_ex, rd_we_ex, is_load_ex, tk_brnch_ex,
    output long_issue_ex, long_done, long_done_rd,
    output rd_addr_mem, rs2_addr_mem, rd_we_mem, is_load_mem, is_store_mem, dmem_busy,
    output rd_addr_wb, rd_we_wb,
`ifdef HZU_PERF_CNT_EN
    input  perf_stall_cyc, perf_sb_stall_cyc, perf_flush_cnt,
`endif
    input  forward_a_sel, forward_b_sel, forward_store_sel,
    input  stall, flush_if_id, flush_id_ex, freeze, sb_pending, sb_full
  );

  modport slave (
    input  rs1_addr_id, rs2_addr_id, rd_addr_id, rd_we_id, is_store_id, is_long_id,
    input  rd_addr_ex, rs1_addr_ex, rs2_addr_ex, rd_we_ex, is_load_ex, tk_brnch_ex,
    input  long_issue_ex, long_done, long_done_rd,
    input  rd_addr_mem, rs2_addr_mem, rd_we_mem, is_load_mem, is_store_mem, dmem_busy,
    input  rd_addr_wb, rd_we_wb,
`ifdef HZU_PERF_CNT_EN
    output perf_stall_cyc, perf_sb_stall_cyc, perf_flush_cnt,
`endif
    output forward_a_sel, forward_b_sel, forward_store_sel,
    output stall, flush_if_id, flush_id_ex, freeze, sb_pending, sb_full
  );
endinterface

// File: rtl/hzu_sb.sv
// hzu_sb: scoreboarded hazard detection and forwarding unit.
// Combinational load-use / store-data / branch handling plus a registered
// pending bit per register for multi-cycle MDU ops and an in-flight counter.
// Optional macro HZU_PERF_CNT_EN adds stall/flush performance counters.
module hzu_sb #(
  parameter int NREG       = 32,
  parameter int AW         = $clog2(NREG),
  parameter int LONG_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input logic     clk,
  input logic     rst,
  hzu_sb_if.slave hz
);
  localparam int            CW      = $clog2(LONG_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(LONG_DEPTH);

  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full_w;
  logic            c_ld_use, c_st_mem, c_st_wb, c_raw, c_waw, c_struct;
  logic            hazard_w, sb_cause_w;

  // Forward-select for one EX source: MEM (non-load) beats WB beats register file.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                         input logic [AW-1:0] rd_mem, input logic we_mem,
                                         input logic ld_mem,
                                         input logic [AW-1:0] rd_wb, input logic we_wb);
    if (we_mem && !ld_mem && rd_mem != '0 && rd_mem == src) return 2'b01;
    else if (we_wb && rd_wb != '0 && rd_wb == src)           return 2'b10;
    else                                                      return 2'b00;
  endfunction

  // Scoreboard next state: completion clears, a same-cycle newer issue re-sets.
  always_comb begin
    pend_d = pend_q;
    if (hz.long_done) pend_d[hz.long_done_rd] = 1'b0;
    if (hz.long_issue_ex && hz.rd_we_ex && hz.rd_addr_ex != '0) pend_d[hz.rd_addr_ex] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // In-flight count: issue and done cancel; a done with nothing in flight is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (hz.long_issue_ex && !hz.long_done)                     cnt_d = cnt_q + CW'(1);
    else if (!hz.long_issue_ex && hz.long_done && cnt_q != '0) cnt_d = cnt_q - CW'(1);
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Hazard causes; scoreboard causes look only at registered bits, so a
  // completing register still stalls for the cycle its done pulse arrives.
  always_comb begin
    full_w     = (cnt_q == DEPTH_C);
    c_ld_use   = hz.is_load_ex && hz.rd_we_ex && hz.rd_addr_ex != '0 &&
                 (hz.rd_addr_ex == hz.rs1_addr_id || hz.rd_addr_ex == hz.rs2_addr_id);
    c_st_mem   = hz.is_store_id && hz.is_load_mem && hz.rd_we_mem &&
                 hz.rd_addr_mem == hz.rs2_addr_id && hz.rs2_addr_id != '0;
    c_st_wb    = hz.is_store_id && hz.rd_we_wb &&
                 hz.rd_addr_wb == hz.rs2_addr_id && hz.rs2_addr_id != '0;
    c_raw      = pend_q[hz.rs1_addr_id] || pend_q[hz.rs2_addr_id];
    c_waw      = hz.rd_we_id && pend_q[hz.rd_addr_id];
    c_struct   = hz.is_long_id && full_w;
    sb_cause_w = c_raw || c_waw || c_struct;
    hazard_w   = c_ld_use || c_st_mem || c_st_wb || sb_cause_w;
  end

  assign hz.freeze      = hz.dmem_busy;
  assign hz.stall       = hazard_w || hz.dmem_busy;
  assign hz.flush_id_ex = (hazard_w || hz.tk_brnch_ex) && !hz.dmem_busy;
  assign hz.flush_if_id = hz.tk_brnch_ex && !hz.dmem_busy;
  assign hz.sb_pending  = pend_q;
  assign hz.sb_full     = full_w;

  assign hz.forward_a_sel = fwd_sel(hz.rs1_addr_ex, hz.rd_addr_mem, hz.rd_we_mem,
                                    hz.is_load_mem, hz.rd_addr_wb, hz.rd_we_wb);
  assign hz.forward_b_sel = fwd_sel(hz.rs2_addr_ex, hz.rd_addr_mem, hz.rd_we_mem,
                                    hz.is_load_mem, hz.rd_addr_wb, hz.rd_we_wb);
  assign hz.forward_store_sel = (hz.is_store_mem && hz.rd_we_wb && hz.rs2_addr_mem != '0 &&
                                 hz.rd_addr_wb == hz.rs2_addr_mem) ? 2'b01 : 2'b00;

`ifdef HZU_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_q, perf_sb_q, perf_flush_q;

  // Free-running event counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_sb_q    <= '0;
      perf_flush_q <= '0;
    end else begin
      if (hz.stall)       perf_stall_q <= perf_stall_q + CNT_W'(1);
      if (sb_cause_w)     perf_sb_q    <= perf_sb_q + CNT_W'(1);
      if (hz.flush_if_id) perf_flush_q <= perf_flush_q + CNT_W'(1);
    end
  end

  assign hz.perf_stall_cyc    = perf_stall_q;
  assign hz.perf_sb_stall_cyc = perf_sb_q;
  assign hz.perf_flush_cnt    = perf_flush_q;
`endif

  // Issuing into a full scoreboard (without a freeing completion) is a pipeline bug.
  a_issue_full: assert property (@(posedge clk) disable iff (rst)
    !(hz.long_issue_ex && !hz.long_done && full_w))
    else $error("hzu_sb: multi-cycle issue while scoreboard full");

  // A completion with nothing in flight is tolerated (e.g. after reset) but flagged.
  a_done_empty: assert property (@(posedge clk) disable iff (rst)
    !(hz.long_done && cnt_q == '0))
    else $warning("hzu_sb: completion with no op in flight, ignored");
endmodule

// File: tb/tb_hzu_sb.sv
// tb_hzu_sb: directed scenarios plus randomized traffic checked against a
// behavioural model (pending set + in-flight list) of the hazard unit.
module tb_hzu_sb;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // Behavioural model state
  logic [NREG-1:0] m_pend;
  int              m_cnt;
  logic [AW-1:0]   inflight[$];
  logic            e_stall, e_fif, e_fie, e_frz, e_full;
  logic [1:0]      e_fa, e_fb, e_fs;

  hzu_sb_if #(.NREG(NREG), .AW(AW)) bus ();
  hzu_sb #(.NREG(NREG), .AW(AW), .LONG_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .hz(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.rs1_addr_id = '0; bus.rs2_addr_id = '0; bus.rd_addr_id = '0;
    bus.rd_we_id = 0; bus.is_store_id = 0; bus.is_long_id = 0;
    bus.rd_addr_ex = '0; bus.rs1_addr_ex = '0; bus.rs2_addr_ex = '0;
    bus.rd_we_ex = 0; bus.is_load_ex = 0; bus.tk_brnch_ex = 0; bus.long_issue_ex = 0;
    bus.long_done = 0; bus.long_done_rd = '0;
    bus.rd_addr_mem = '0; bus.rs2_addr_mem = '0; bus.rd_we_mem = 0;
    bus.is_load_mem = 0; bus.is_store_mem = 0; bus.dmem_busy = 0;
    bus.rd_addr_wb = '0; bus.rd_we_wb = 0;
  endtask

  function automatic logic [1:0] fwd_of(input logic [AW-1:0] src);
    if (src == 0) return 2'b00;
    if (bus.rd_we_mem && !bus.is_load_mem && bus.rd_addr_mem == src) return 2'b01;
    if (bus.rd_we_wb && bus.rd_addr_wb == src) return 2'b10;
    return 2'b00;
  endfunction

  // Expected outputs from the hazard rules applied to current inputs and model state.
  task automatic model_eval();
    logic ex_load_hit, st_hit, sb_hit;
    ex_load_hit = bus.is_load_ex && bus.rd_we_ex && bus.rd_addr_ex != 0 &&
                  (bus.rs1_addr_id == bus.rd_addr_ex || bus.rs2_addr_id == bus.rd_addr_ex);
    st_hit = bus.is_store_id && bus.rs2_addr_id != 0 &&
             ((bus.is_load_mem && bus.rd_we_mem && bus.rd_addr_mem == bus.rs2_addr_id) ||
              (bus.rd_we_wb && bus.rd_addr_wb == bus.rs2_addr_id));
    e_full = (m_cnt == DEPTH);
    sb_hit = m_pend[bus.rs1_addr_id] || m_pend[bus.rs2_addr_id] ||
             (bus.rd_we_id && m_pend[bus.rd_addr_id]) || (bus.is_long_id && e_full);
    e_frz   = bus.dmem_busy;
    e_stall = ex_load_hit || st_hit || sb_hit || e_frz;
    e_fif   = bus.tk_brnch_ex && !e_frz;
    e_fie   = (ex_load_hit || st_hit || sb_hit || bus.tk_brnch_ex) && !e_frz;
    e_fa = fwd_of(bus.rs1_addr_ex);
    e_fb = fwd_of(bus.rs2_addr_ex);
    e_fs = (bus.is_store_mem && bus.rd_we_wb && bus.rs2_addr_mem != 0 &&
            bus.rd_addr_wb == bus.rs2_addr_mem) ? 2'b01 : 2'b00;
  endtask

  // Apply this cycle's MDU pulses to the model, then advance one clock.
  task automatic tick();
    if (bus.long_issue_ex && !bus.long_done) m_cnt++;
    else if (!bus.long_issue_ex && bus.long_done && m_cnt > 0) m_cnt--;
    if (bus.long_done) m_pend[bus.long_done_rd] = 1'b0;
    if (bus.long_issue_ex && bus.rd_we_ex && bus.rd_addr_ex != 0) m_pend[bus.rd_addr_ex] = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    clear_inputs();
    bus.long_issue_ex = 1; bus.rd_we_ex = 1; bus.rd_addr_ex = rd;
    $display("issue rd=%0d", rd);
    tick();
  endtask

  task automatic done(input logic [AW-1:0] rd);
    clear_inputs();
    bus.long_done = 1; bus.long_done_rd = rd;
    $display("done rd=%0d", rd);
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.sb_pending !== '0) begin errors++; $display("FAIL reset_pending got=%h exp=0", bus.sb_pending); end
    checks++; if (bus.sb_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.sb_full); end
    checks++;
    if ({bus.stall, bus.flush_if_id, bus.flush_id_ex, bus.freeze} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {bus.stall, bus.flush_if_id, bus.flush_id_ex, bus.freeze});
    end
    rst = 0; m_pend = '0; m_cnt = 0; inflight.delete();
    @(negedge clk);
    $display("reset checked");
  endtask

  task automatic test_load_use();
    clear_inputs();
    bus.is_load_ex = 1; bus.rd_we_ex = 1; bus.rd_addr_ex = 10; bus.rs1_addr_id = 10;
    #1;
    checks++;
    if ({bus.stall, bus.flush_id_ex, bus.flush_if_id} !== 3'b110) begin
      errors++; $display("FAIL load_use got stall/fie/fif=%b exp=110", {bus.stall, bus.flush_id_ex, bus.flush_if_id});
    end
    bus.rd_addr_ex = 0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL load_use_x0 stall got=%b exp=0", bus.stall); end
    $display("load-use rd_ex=10/0 checked");
    clear_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    issue(7);
    clear_inputs();
    #1;
    checks++; if (bus.sb_pending[7] !== 1'b1) begin errors++; $display("FAIL sb_set pending[7] got=%b exp=1", bus.sb_pending[7]); end
    bus.rs2_addr_id = 7;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sb_raw stall got=%b exp=1", bus.stall); end
    bus.long_done = 1; bus.long_done_rd = 7;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sb_done_same_cycle stall got=%b exp=1", bus.stall); end
    tick();
    bus.long_done = 0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sb_cleared stall got=%b exp=0", bus.stall); end
    checks++; if (bus.sb_pending !== '0) begin errors++; $display("FAIL sb_cleared pending got=%h exp=0", bus.sb_pending); end
    $display("scoreboard RAW on x7 checked");
    clear_inputs();
  endtask

  task automatic test_depth();
    issue(3);
    issue(4);
    clear_inputs();
    #1;
    checks++; if (bus.sb_full !== 1'b1) begin errors++; $display("FAIL depth_full got=%b exp=1", bus.sb_full); end
    bus.is_long_id = 1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL depth_struct stall got=%b exp=1", bus.stall); end
    clear_inputs();
    bus.long_issue_ex = 1; bus.rd_we_ex = 1; bus.rd_addr_ex = 3; bus.long_done = 1; bus.long_done_rd = 3;
    tick();
    clear_inputs();
    #1;
    checks++; if (bus.sb_pending[4:3] !== 2'b11) begin errors++; $display("FAIL collision pending[4:3] got=%b exp=11", bus.sb_pending[4:3]); end
    checks++; if (bus.sb_full !== 1'b1) begin errors++; $display("FAIL collision full got=%b exp=1", bus.sb_full); end
    done(3);
    done(4);
    clear_inputs();
    #1;
    checks++; if ({bus.sb_full, bus.sb_pending} !== '0) begin errors++; $display("FAIL depth_drain full=%b pending=%h exp=0/0", bus.sb_full, bus.sb_pending); end
    $display("depth/collision checked");
  endtask

  task automatic test_freeze();
    clear_inputs();
    bus.dmem_busy = 1; bus.tk_brnch_ex = 1;
    bus.long_issue_ex = 1; bus.rd_we_ex = 1; bus.rd_addr_ex = 9;
    #1;
    checks++;
    if ({bus.freeze, bus.stall, bus.flush_if_id, bus.flush_id_ex} !== 4'b1100) begin
      errors++; $display("FAIL freeze got frz/stall/fif/fie=%b exp=1100", {bus.freeze, bus.stall, bus.flush_if_id, bus.flush_id_ex});
    end
    tick();
    bus.dmem_busy = 0; bus.long_issue_ex = 0; bus.rd_we_ex = 0; bus.rd_addr_ex = 0;
    #1;
    checks++; if ({bus.flush_if_id, bus.flush_id_ex} !== 2'b11) begin errors++; $display("FAIL unfreeze flush got=%b exp=11", {bus.flush_if_id, bus.flush_id_ex}); end
    checks++; if (bus.sb_pending[9] !== 1'b1) begin errors++; $display("FAIL freeze_sb pending[9] got=%b exp=1", bus.sb_pending[9]); end
    $display("freeze with held branch checked");
    done(9);
    clear_inputs();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    bus.rd_addr_mem = 5; bus.rd_we_mem = 1; bus.rd_addr_wb = 5; bus.rd_we_wb = 1; bus.rs1_addr_ex = 5;
    #1;
    checks++; if (bus.forward_a_sel !== 2'b01) begin errors++; $display("FAIL fwd_mem got=%b exp=01", bus.forward_a_sel); end
    bus.is_load_mem = 1;
    #1;
    checks++; if (bus.forward_a_sel !== 2'b10) begin errors++; $display("FAIL fwd_wb got=%b exp=10", bus.forward_a_sel); end
    bus.is_store_mem = 1; bus.rs2_addr_mem = 15; bus.rd_addr_wb = 15;
    #1;
    checks++; if (bus.forward_store_sel !== 2'b01) begin errors++; $display("FAIL fwd_store got=%b exp=01", bus.forward_store_sel); end
    checks++; if (bus.forward_a_sel !== 2'b00) begin errors++; $display("FAIL fwd_reg got=%b exp=00", bus.forward_a_sel); end
    bus.is_store_id = 1; bus.rs2_addr_id = 15;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL store_wb_stall got=%b exp=1", bus.stall); end
    $display("forwarding MEM/WB/store checked");
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int idx;
    logic [10:0] got, exp;
    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      bus.rs1_addr_id = AW'($urandom_range(0, 7)); bus.rs2_addr_id = AW'($urandom_range(0, 7));
      bus.rd_addr_id = AW'($urandom_range(0, 7)); bus.rd_we_id = 1'($urandom_range(0, 1));
      bus.is_store_id = ($urandom_range(0, 3) == 0); bus.is_long_id = ($urandom_range(0, 3) == 0);
      bus.rd_addr_ex = AW'($urandom_range(0, 7)); bus.rs1_addr_ex = AW'($urandom_range(0, 7));
      bus.rs2_addr_ex = AW'($urandom_range(0, 7)); bus.rd_we_ex = 1'($urandom_range(0, 1));
      bus.is_load_ex = ($urandom_range(0, 3) == 0); bus.tk_brnch_ex = ($urandom_range(0, 5) == 0);
      bus.rd_addr_mem = AW'($urandom_range(0, 7)); bus.rs2_addr_mem = AW'($urandom_range(0, 7));
      bus.rd_we_mem = 1'($urandom_range(0, 1)); bus.is_load_mem = ($urandom_range(0, 2) == 0);
      bus.is_store_mem = ($urandom_range(0, 2) == 0); bus.dmem_busy = ($urandom_range(0, 4) == 0);
      bus.rd_addr_wb = AW'($urandom_range(0, 7)); bus.rd_we_wb = 1'($urandom_range(0, 1));
      if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, inflight.size() - 1);
        bus.long_done = 1; bus.long_done_rd = inflight[idx];
        inflight.delete(idx);
      end
      if (m_cnt < DEPTH && $urandom_range(0, 2) == 0) begin
        bus.long_issue_ex = 1;
        inflight.push_back(bus.rd_addr_ex);
      end
      model_eval();
      #1;
      got = {bus.stall, bus.flush_if_id, bus.flush_id_ex, bus.freeze, bus.forward_a_sel,
             bus.forward_b_sel, bus.forward_store_sel, bus.sb_full};
      exp = {e_stall, e_fif, e_fie, e_frz, e_fa, e_fb, e_fs, e_full};
      checks++; if (got !== exp) begin errors++; $display("FAIL rand_ctrl cyc=%0d got=%h exp=%h", n, got, exp); end
      checks++; if (bus.sb_pending !== m_pend) begin errors++; $display("FAIL rand_pending cyc=%0d got=%h exp=%h", n, bus.sb_pending, m_pend); end
      $display("rand cyc=%0d iss=%b done=%b ctrl=%h pend=%h", n, bus.long_issue_ex, bus.long_done, got, bus.sb_pending);
      tick();
    end
    while (inflight.size() > 0) done(inflight.pop_front());
    clear_inputs();
  endtask

  task automatic test_reset_midop();
    issue(3);
    issue(4);
    clear_inputs();
    #1;
    rst = 1;
    #1;
    checks++; if (bus.sb_pending !== '0) begin errors++; $display("FAIL midrst_pending got=%h exp=0", bus.sb_pending); end
    checks++; if (bus.sb_full !== 1'b0) begin errors++; $display("FAIL midrst_full got=%b exp=0", bus.sb_full); end
    m_pend = '0; m_cnt = 0; inflight.delete();
    @(negedge clk);
    rst = 0;
    done(3);
    clear_inputs();
    #1;
    checks++; if (bus.sb_full !== 1'b0) begin errors++; $display("FAIL late_done full got=%b exp=0", bus.sb_full); end
    issue(5);
    #1;
    checks++; if (bus.sb_full !== 1'b0) begin errors++; $display("FAIL after_late_done one_op full got=%b exp=0", bus.sb_full); end
    issue(6);
    #1;
    checks++; if (bus.sb_full !== 1'b1) begin errors++; $display("FAIL after_late_done two_ops full got=%b exp=1", bus.sb_full); end
    $display("reset mid-operation checked");
    done(5);
    done(6);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_scoreboard();
    test_depth();
    test_freeze();
    test_forwarding();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hzu_sb.md
Name: hzu_sb

Overview:
- Scoreboarded hazard detection and forwarding unit for the 5-stage pipeline. Successor to the combinational hazard unit.
- Keeps existing functions: load-use stall, MEM/WB→EX forwarding, WB→MEM store-data forwarding, branch flush.
- Adds a registered per-register pending scoreboard for multi-cycle ops (MDU divide/multiply), a bounded in-flight counter, and a whole-pipeline freeze on data-memory wait.
- Sits beside the pipeline registers; drives the stall, flush, freeze and forward-select controls.

Parameters:
- NREG, 32, number of architectural registers; x0 is hardwired zero.
- AW, $clog2(NREG), register address width.
- LONG_DEPTH, 2, maximum outstanding multi-cycle ops (≥1).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- rs1_addr_id, rs2_addr_id, rd_addr_id  in  AW  ID source/destination registers
- rd_we_id, is_store_id, is_long_id  in  1  ID writes rd / is store / is multi-cycle op
- rd_addr_ex, rs1_addr_ex, rs2_addr_ex  in  AW  EX registers
- rd_we_ex, is_load_ex, tk_brnch_ex  in  1  EX control
- long_issue_ex  in  1  one-cycle pulse: multi-cycle op accepted by MDU this cycle
- long_done, long_done_rd  in  1, AW  MDU completion pulse and its destination
- rd_addr_mem, rs2_addr_mem  in  AW  MEM registers
- rd_we_mem, is_load_mem, is_store_mem, dmem_busy  in  1  MEM control; dmem_busy = memory not ready
- rd_addr_wb, rd_we_wb  in  AW, 1  WB write port
- forward_a_sel, forward_b_sel  out  2  00 REG, 01 MEM, 10 WB
- forward_store_sel  out  2  00 normal, 01 WB
- stall, flush_if_id, flush_id_ex, freeze  out  1
- sb_pending  out  NREG  scoreboard bits
- sb_full  out  1  in-flight count == LONG_DEPTH

Behaviour:
- Reset (async):
  - sb_pending=0, in-flight count=0, perf counters=0.
  - Combinational outputs then follow their inputs with an empty scoreboard.
- Scoreboard, updated on the rising edge:
  - Set pending[rd_addr_ex] when long_issue_ex && rd_we_ex && rd_addr_ex≠0.
  - Clear pending[long_done_rd] when long_done.
  - Same register set and cleared in the same cycle → set wins (newer op).
  - Bit 0 is never set.
- In-flight count:
  - +1 on long_issue_ex, −1 on long_done; both in the same cycle → unchanged.
  - long_done at count 0 is ignored (saturates at 0; simulation assertion fires).
  - Issue at count LONG_DEPTH must not occur (assertion).
- Stall (combinational) is the OR of:
  - (a) load-use: is_load_ex && rd_we_ex && rd_addr_ex≠0 && rd_addr_ex matches rs1_addr_id or rs2_addr_id.
  - (b) store-data from load in MEM: is_store_id && is_load_mem && rd_we_mem && rd_addr_mem==rs2_addr_id≠0.
  - (c) store-data from WB, conservative: is_store_id && rd_we_wb && rd_addr_wb==rs2_addr_id≠0.
  - (d) RAW on scoreboard: pending[rs1_addr_id] or pending[rs2_addr_id].
  - (e) WAW: rd_we_id && pending[rd_addr_id].
  - (f) structural: is_long_id && sb_full.
  - (g) freeze.
- Scoreboard stalls use registered bits only. A register whose long_done arrives this cycle is still pending for this cycle's decision (one-cycle conservative penalty).
- flush_id_ex:
  - (stall-cause a–f || tk_brnch_ex) && !freeze.
  - flush_if_id = tk_brnch_ex && !freeze.
  - A branch plus a load-use hazard gives stall=1 and both flushes=1.
- freeze = dmem_busy. While freeze=1:
  - All flushes are 0.
  - The scoreboard and count keep updating from MDU pulses.
  - A taken branch held in EX flushes in the first cycle after freeze drops.
- Forwarding A/B:
  - MEM when rd_we_mem && !is_load_mem && rd_addr_mem≠0 && match; else WB when rd_we_wb && rd_addr_wb≠0 && match; else REG.
  - MEM has priority over WB.
- forward_store_sel = WB when is_store_mem && rd_we_wb && rd_addr_wb==rs2_addr_mem≠0.
- Reset mid-operation clears everything. Late long_done pulses after reset are harmless: the count saturates at 0 and clearing a clear bit is a no-op.

Optional Feature:
- Macro: HZU_PERF_CNT_EN.
- When defined, adds three outputs, each CNT_W bits wide and wrapping modulo 2^CNT_W:
  - perf_stall_cyc: +1 on every cycle with stall=1.
  - perf_sb_stall_cyc: +1 on cycles where cause (d), (e) or (f) is active.
  - perf_flush_cnt: +1 on every cycle with flush_if_id=1.
- All three counters reset to 0.
- When not defined, these ports and their logic are absent.

Test Plan:
- Load-use: is_load_ex=1, rd_we_ex=1, rd_addr_ex=10, rs1_addr_id=10 → stall=1, flush_id_ex=1, flush_if_id=0; same with rd_addr_ex=0 → stall=0.
- Scoreboard RAW: pulse long_issue_ex with rd_addr_ex=7 → next cycle sb_pending[7]=1; rs2_addr_id=7 → stall=1. Pulse long_done with rd=7 → stall=0 one cycle later.
- Depth and collision (LONG_DEPTH=2):
  - Issue rd=3 and rd=4 → sb_full=1; is_long_id=1 → stall=1.
  - Same-cycle done rd=3 and issue rd=3 → pending[3] stays 1, count stays 2.
- Freeze: dmem_busy=1 with tk_brnch_ex=1 → freeze=1, stall=1, flushes 0; drop dmem_busy → flush_if_id=1 and flush_id_ex=1.
- Forwarding: rd_mem=5 (we=1) and rd_wb=5 (we=1), rs1_ex=5 → fwd_a=01; set is_load_mem=1 → fwd_a=10; is_store_mem=1, rs2_mem=15, rd_wb=15 → fwd_st=01.
- Reset mid-op: two ops in flight, assert rst → sb_pending=0 and sb_full=0 immediately; a subsequent long_done leaves the count at 0.
